// File: rtl/sub64_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// sub64_arbiter_pkg
//   Shared types for the sub64 arbiter slice: FSM state encoding and the
//   flag bit ordering used by downstream flag registers (bit0 Z, bit1 C,
//   bit2 O).
// -----------------------------------------------------------------------------
package sub64_arbiter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int FLAG_ZF = 0;
    localparam int FLAG_CF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_W  = 3;

    // Packed so that of/cf/zf land on FLAG_OF/FLAG_CF/FLAG_ZF.
    typedef struct packed {
        logic of;
        logic cf;
        logic zf;
    } flags_t;

endpackage

// File: rtl/sub64_arbiter_if.sv
// -----------------------------------------------------------------------------
// sub64_arbiter_if
//   Request/response bundle between the execute-stage clients and the shared
//   subtractor arbiter.
//   master : clients / result consumer (drive requests, accept results)
//   slave  : the arbiter
//   req_valid/req_ready : per-requester handshake (ready is one-hot or zero)
//   req_a/req_b         : operands, requester k at [k*WIDTH +: WIDTH]
//   resp_*              : result handshake, owner id, difference and flags
// -----------------------------------------------------------------------------
interface sub64_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ*WIDTH-1:0] req_a;
    logic [NUM_REQ*WIDTH-1:0] req_b;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [ID_W-1:0]          resp_id;
    logic [WIDTH-1:0]         resp_diff;
    logic                     resp_zf;
    logic                     resp_cf;
    logic                     resp_of;

    modport master (
        output req_valid, req_a, req_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_diff, resp_zf, resp_cf, resp_of
    );

    modport slave (
        input  req_valid, req_a, req_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_diff, resp_zf, resp_cf, resp_of
    );
endinterface

// File: rtl/sub64_arbiter_sub64.sv
// -----------------------------------------------------------------------------
// sub64
//   Combinational subtract/compare datapath.
//   a_i, b_i : operands
//   diff_o   : a - b mod 2^WIDTH
//   zf_o     : diff == 0
//   cf_o     : borrow (a < b unsigned)
//   of_o     : signed overflow
// -----------------------------------------------------------------------------
module sub64 #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             zf_o,
    output logic             cf_o,
    output logic             of_o
);
    logic [WIDTH:0] sum;

    // a + ~b + 1; the carry out of the MSB is the inverse of the borrow.
    assign sum    = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
    assign diff_o = sum[WIDTH-1:0];
    assign cf_o   = ~sum[WIDTH];
    assign zf_o   = (sum[WIDTH-1:0] == '0);
    // Overflow only when operand signs differ and the result sign leaves a's.
    assign of_o   = (a_i[WIDTH-1] ^ b_i[WIDTH-1]) & (a_i[WIDTH-1] ^ sum[WIDTH-1]);
endmodule

// File: rtl/sub64_arbiter.sv
// -----------------------------------------------------------------------------
// sub64_arbiter
//   Shares one sub64 datapath between NUM_REQ requesters. Round-robin grant in
//   IDLE, operands registered on accept, one EXEC cycle, result held in RESP
//   until the consumer takes it.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : request/response bundle (slave side)
// -----------------------------------------------------------------------------
module sub64_arbiter
    import sub64_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
) (
    input logic           clk,
    input logic           rst_n,
    sub64_arbiter_if.slave bus
);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d;
    logic [WIDTH-1:0]   op_b_q, op_b_d;
    logic [ID_W-1:0]    op_id_q, op_id_d;
    logic               resp_valid_q, resp_valid_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic [WIDTH-1:0]   resp_diff_q, resp_diff_d;
    flags_t             flags_q, flags_d;

    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_idx;
    logic [NUM_REQ-1:0] ready_c;

    logic [WIDTH-1:0]   sub_diff;
    logic               sub_zf, sub_cf, sub_of;

    // Round-robin pick: scan offsets high to low so the closest valid
    // requester at or after rr_ptr is the last (winning) assignment.
    always_comb begin : rr_pick
        int idx;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (bus.req_valid[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = ID_W'(idx);
            end
        end
    end

    sub64 #(.WIDTH(WIDTH)) u_sub64 (
        .a_i    (op_a_q),
        .b_i    (op_b_q),
        .diff_o (sub_diff),
        .zf_o   (sub_zf),
        .cf_o   (sub_cf),
        .of_o   (sub_of)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        op_id_d      = op_id_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_diff_d  = resp_diff_q;
        flags_d      = flags_q;
        ready_c      = '0;

        case (state_q)
            S_IDLE: begin
                // Ready is raised for the winner whenever one exists, so a
                // grant is always a handshake.
                if (gnt_vld) begin
                    ready_c[gnt_idx] = 1'b1;
                    op_a_d   = bus.req_a[int'(gnt_idx)*WIDTH +: WIDTH];
                    op_b_d   = bus.req_b[int'(gnt_idx)*WIDTH +: WIDTH];
                    op_id_d  = gnt_idx;
                    rr_ptr_d = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                resp_diff_d  = sub_diff;
                flags_d      = '{of: sub_of, cf: sub_cf, zf: sub_zf};
                resp_id_d    = op_id_q;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_id_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_diff_q  <= '0;
            flags_q      <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            op_id_q      <= op_id_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_diff_q  <= resp_diff_d;
            flags_q      <= flags_d;
        end
    end

    // No grant may be visible while reset is held, regardless of state.
    assign bus.req_ready  = rst_n ? ready_c : '0;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_id    = resp_id_q;
    assign bus.resp_diff  = resp_diff_q;
    assign bus.resp_zf    = flags_q.zf;
    assign bus.resp_cf    = flags_q.cf;
    assign bus.resp_of    = flags_q.of;

endmodule

// File: tb/tb_sub64_arbiter.sv
module tb_sub64_arbiter;
    localparam int N = 4;
    localparam int W = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   rr_m = 0;
    logic [63:0] a_m [N];
    logic [63:0] b_m [N];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sub64_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) bus ();

    sub64_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Round-robin winner from the model pointer; -1 when nobody asks.
    function automatic int pick(input logic [N-1:0] m, input int ptr);
        for (int i = 0; i < N; i++) begin
            int k;
            k = (ptr + i) % N;
            if (m[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] v;
        v = '0;
        if (k >= 0) v[k] = 1'b1;
        return v;
    endfunction

    // {of, cf, zf, diff} from plain arithmetic on the operand values.
    function automatic logic [66:0] ref_sub(input logic [63:0] a, input logic [63:0] b);
        logic signed [64:0] t, mx, mn;
        logic [63:0] d;
        logic zf, cf, of;
        d  = a - b;
        zf = (a == b);
        cf = (a < b);
        t  = $signed({a[63], a}) - $signed({b[63], b});
        mx = $signed({2'b00, {63{1'b1}}});
        mn = $signed({2'b11, {63{1'b0}}});
        of = (t > mx) || (t < mn);
        return {of, cf, zf, d};
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return {64{1'b1}};
            3:       return {1'b1, 63'd0};
            4:       return {1'b0, {63{1'b1}}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic set_req(input int k, input logic [63:0] a, input logic [63:0] b);
        a_m[k] = a;
        b_m[k] = b;
        bus.req_a[k*W +: W] = a;
        bus.req_b[k*W +: W] = b;
    endtask

    // Called just after a negedge with the DUT idle. Runs one full
    // request/response exchange; bp = cycles of resp_ready=0 in RESP.
    task automatic serve(input logic [N-1:0] mask, input int bp, input bit keep, output int g);
        logic [63:0] ea, eb;
        logic [66:0] r;
        bus.req_valid  = mask;
        bus.resp_ready = 1'b0;
        #1;
        g = pick(mask, rr_m);
        chk("idle_ready", {60'd0, bus.req_ready}, {60'd0, onehot(g)});
        if (g < 0) begin
            @(negedge clk);
            return;
        end
        ea   = a_m[g];
        eb   = b_m[g];
        r    = ref_sub(ea, eb);
        rr_m = (g + 1) % N;
        @(negedge clk);
        if (!keep) bus.req_valid[g] = 1'b0;
        #1;
        chk("exec_ready", {60'd0, bus.req_ready}, 64'd0);
        chk("exec_rv", {63'd0, bus.resp_valid}, 64'd0);
        @(negedge clk);
        chk("resp_rv", {63'd0, bus.resp_valid}, 64'd1);
        chk("resp_id", {62'd0, bus.resp_id}, 64'(g));
        chk("resp_diff", bus.resp_diff, r[63:0]);
        chk("resp_zf", {63'd0, bus.resp_zf}, {63'd0, r[64]});
        chk("resp_cf", {63'd0, bus.resp_cf}, {63'd0, r[65]});
        chk("resp_of", {63'd0, bus.resp_of}, {63'd0, r[66]});
        if (bp == 0) bus.resp_ready = 1'b1;
        for (int c = 0; c < bp; c++) begin
            @(negedge clk);
            chk("hold_rv", {63'd0, bus.resp_valid}, 64'd1);
            chk("hold_diff", bus.resp_diff, r[63:0]);
            chk("hold_id", {62'd0, bus.resp_id}, 64'(g));
            chk("hold_ready", {60'd0, bus.req_ready}, 64'd0);
            if (c == bp - 1) bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("post_rv", {63'd0, bus.resp_valid}, 64'd0);
        chk("post_diff", bus.resp_diff, r[63:0]);
        bus.resp_ready = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int g;
        int t_prev;
        int order [5];
        logic [N-1:0] mask, old;

        order = '{0, 1, 2, 3, 0};
        bus.req_valid  = '1;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 64'd0, 64'd0);

        // Reset: no grant while held, clean response registers after the edge.
        #1;
        chk("rst_ready_comb", {60'd0, bus.req_ready}, 64'd0);
        repeat (2) @(negedge clk);
        chk("rst_ready", {60'd0, bus.req_ready}, 64'd0);
        chk("rst_rv", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_id", {62'd0, bus.resp_id}, 64'd0);
        chk("rst_diff", bus.resp_diff, 64'd0);
        chk("rst_flags", {61'd0, bus.resp_of, bus.resp_cf, bus.resp_zf}, 64'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single op, borrow, zero, overflow.
        set_req(0, 64'd10, 64'd3);
        serve(4'b0001, 0, 1'b0, g);
        chk("t1_diff", bus.resp_diff, 64'd7);
        set_req(0, 64'd3, 64'd10);
        serve(4'b0001, 0, 1'b0, g);
        chk("t2_diff", bus.resp_diff, 64'hFFFF_FFFF_FFFF_FFF9);
        chk("t2_cf", {63'd0, bus.resp_cf}, 64'd1);
        set_req(0, 64'h55, 64'h55);
        serve(4'b0001, 0, 1'b0, g);
        chk("t2_zf", {63'd0, bus.resp_zf}, 64'd1);
        set_req(0, 64'h8000_0000_0000_0000, 64'd1);
        serve(4'b0001, 0, 1'b0, g);
        chk("t3_diff", bus.resp_diff, 64'h7FFF_FFFF_FFFF_FFFF);
        chk("t3_of", {63'd0, bus.resp_of}, 64'd1);

        // Fairness: everyone asks continuously, one accept every 3 cycles.
        rr_m = 1;   // model pointer after serving requester 0 above
        set_req(1, rnd64(), rnd64());
        set_req(2, rnd64(), rnd64());
        set_req(3, rnd64(), rnd64());
        serve(4'b0010, 0, 1'b0, g);   // realign pointer so the next winner is 2
        serve(4'b0100, 0, 1'b0, g);
        serve(4'b1000, 0, 1'b0, g);   // pointer back to 0
        t_prev = -1;
        for (int i = 0; i < 5; i++) begin
            if (t_prev >= 0) chk("fair_spacing", 64'(cyc - t_prev), 64'd3);
            t_prev = cyc;
            serve(4'b1111, 0, 1'b1, g);
            chk("fair_order", 64'(g), 64'(order[i]));
        end

        // Backpressure with competing requests pending.
        set_req(1, rnd64(), rnd64());
        set_req(2, rnd64(), rnd64());
        serve(4'b0110, 5, 1'b0, g);
        serve(bus.req_valid, 0, 1'b0, g);  // loser accepted right after handshake

        // Randomized traffic with withdrawals and variable backpressure.
        for (int it = 0; it < 40; it++) begin
            old  = bus.req_valid;
            mask = 4'($urandom_range(0, 15));
            for (int k = 0; k < N; k++)
                if (!old[k] || !mask[k]) set_req(k, rnd64(), rnd64());
            serve(mask, $urandom_range(0, 3), 1'b0, g);
        end

        // Reset during EXEC: op dropped, pointer back to 0.
        bus.req_valid = '0;
        @(negedge clk);
        serve(4'b0100, 0, 1'b0, g);        // pointer -> 3
        set_req(1, 64'd100, 64'd1);
        bus.req_valid = 4'b0010;
        #1;
        chk("mid_ready", {60'd0, bus.req_ready}, {60'd0, onehot(pick(4'b0010, rr_m))});
        @(negedge clk);                    // EXEC now
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {60'd0, bus.req_ready}, 64'd0);
        @(negedge clk);
        chk("mid_rv", {63'd0, bus.resp_valid}, 64'd0);
        chk("mid_diff", bus.resp_diff, 64'd0);
        rst_n = 1'b1;
        bus.req_valid = '0;
        rr_m = 0;
        repeat (3) begin
            @(negedge clk);
            chk("drop_rv", {63'd0, bus.resp_valid}, 64'd0);
        end
        set_req(3, 64'd5, 64'd6);
        serve(4'b1010, 0, 1'b0, g);
        chk("rr_after_rst", 64'(g), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
